// File: rtl/mmc1_reg_sequencer.sv
// MMC1 register-write sequencer: round-robin arbiter feeding the five-write serial load protocol.
// Optional abort support is compiled in with `define MMC1_SEQ_ABORT_EN.
module mmc1_reg_sequencer #(
  parameter int unsigned GAP_CYCLES = 1  // legal 1..15
) (
  input  logic       CPU_M2,
  input  logic       RESET,
  input  logic       REQ_A,
  input  logic [1:0] REQ_A_REG,
  input  logic [4:0] REQ_A_DATA,
  input  logic       REQ_A_RST,
  output logic       GNT_A,
  input  logic       REQ_B,
  input  logic [1:0] REQ_B_REG,
  input  logic [4:0] REQ_B_DATA,
  input  logic       REQ_B_RST,
  output logic       GNT_B,
  input  logic       ABORT,
  output logic       WR_STB,
  output logic       WR_A14,
  output logic       WR_A13,
  output logic       WR_D0,
  output logic       WR_D7,
  output logic       BUSY,
  output logic       DONE,
  output logic       DONE_ID,
  output logic       ABORTED
);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP, S_DONE} state_t;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [2:0] bit_idx;
  logic [4:0] cur_data;
  logic       cur_id;
  logic       rst_mode;     // current sequence ends after its single D7 write
  logic       abort_pend;
  logic       abort_flag;
  logic       last_b;

  logic       pick_b;
  logic [1:0] sel_reg;
  logic [4:0] sel_data;
  logic       sel_rst;
  logic [2:0] next_idx;
  logic       abort_hit;
  logic       abort_now;

  // Round-robin: B wins only when A is idle or A was granted last.
  assign pick_b   = REQ_B && (!REQ_A || !last_b);
  assign sel_reg  = pick_b ? REQ_B_REG  : REQ_A_REG;
  assign sel_data = pick_b ? REQ_B_DATA : REQ_A_DATA;
  assign sel_rst  = pick_b ? REQ_B_RST  : REQ_A_RST;
  assign next_idx = bit_idx + 3'd1;

`ifdef MMC1_SEQ_ABORT_EN
  assign abort_hit = ABORT && !rst_mode && ((state == S_STROBE) || (state == S_GAP));
`else
  logic unused_abort;
  assign unused_abort = ABORT;
  assign abort_hit    = 1'b0;
`endif

  assign abort_now = abort_pend || abort_hit;

  always_ff @(posedge CPU_M2) begin
    if (RESET) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      bit_idx    <= '0;
      cur_data   <= '0;
      cur_id     <= 1'b0;
      rst_mode   <= 1'b0;
      abort_pend <= 1'b0;
      abort_flag <= 1'b0;
      last_b     <= 1'b1;
      GNT_A      <= 1'b0;
      GNT_B      <= 1'b0;
      WR_STB     <= 1'b0;
      WR_A14     <= 1'b0;
      WR_A13     <= 1'b0;
      WR_D0      <= 1'b0;
      WR_D7      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      DONE_ID    <= 1'b0;
      ABORTED    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default to 0 every cycle; only the branch that owns them re-asserts them.
      GNT_A   <= 1'b0;
      GNT_B   <= 1'b0;
      WR_STB  <= 1'b0;
      WR_D0   <= 1'b0;
      WR_D7   <= 1'b0;
      DONE    <= 1'b0;
      DONE_ID <= 1'b0;
      ABORTED <= 1'b0;

      case (state)
        S_IDLE: begin
          if (REQ_A || REQ_B) begin
            state      <= S_STROBE;
            GNT_A      <= !pick_b;
            GNT_B      <= pick_b;
            last_b     <= pick_b;
            cur_id     <= pick_b;
            cur_data   <= sel_data;
            rst_mode   <= sel_rst;
            bit_idx    <= '0;
            abort_pend <= 1'b0;
            abort_flag <= 1'b0;
            BUSY       <= 1'b1;
            WR_A14     <= sel_reg[1];
            WR_A13     <= sel_reg[0];
            WR_STB     <= 1'b1;
            WR_D7      <= sel_rst;
            WR_D0      <= sel_rst ? 1'b0 : sel_data[0];
          end
        end

        S_STROBE: begin
          state   <= S_GAP;
          gap_cnt <= 4'(GAP_CYCLES - 1);
          if (abort_hit) abort_pend <= 1'b1;
        end

        S_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
            if (abort_hit) abort_pend <= 1'b1;
          end else if (abort_now) begin
            // Aborted load: flush the mapper shift register with one reset write.
            state      <= S_STROBE;
            rst_mode   <= 1'b1;
            abort_pend <= 1'b0;
            abort_flag <= 1'b1;
            WR_STB     <= 1'b1;
            WR_D7      <= 1'b1;
          end else if (rst_mode || (bit_idx == 3'd4)) begin
            state   <= S_DONE;
            DONE    <= 1'b1;
            DONE_ID <= cur_id;
            ABORTED <= abort_flag;
          end else begin
            state   <= S_STROBE;
            bit_idx <= next_idx;
            WR_STB  <= 1'b1;
            WR_D0   <= cur_data[next_idx];
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          BUSY   <= 1'b0;
          WR_A14 <= 1'b0;
          WR_A13 <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
